// File: rtl/acq_readout_scheduler.sv
// -----------------------------------------------------------------------------
// acq_readout_scheduler
//
// Purpose:
//   Takes one acquisition event word from the Acquisition Event FIFO and then
//   reads out every channel FPGA that was enabled when the event was taken.
//   Channels are served in ascending index order, one at a time. Each channel
//   request ends on that channel's acknowledge or on a per-channel timeout.
//   When every enabled channel has been handled, readout_done pulses for one
//   cycle.
//
// Parameters:
//   TIMEOUT_CYCLES  per-channel readout timeout in clk cycles (2 .. 2^24-1)
//
// Ports:
//   clk            in   1   40 MHz TTC clock
//   reset          in   1   asynchronous, active-high reset
//   chan_en        in   5   channel enable mask, sampled when the event is popped
//   evt_valid      in   1   FIFO read side: an event word is available
//   evt_data       in  32   event word {5'd0, trig_type[2:0], trig_num[23:0]}
//   evt_ready      out  1   pop strobe (high in IDLE)
//   chan_rd_req    out  5   one-hot readout request, held until ack or timeout
//   chan_rd_ack    in   5   per-channel readout-complete pulse
//   readout_done   out  1   one-cycle pulse when the event readout finishes
//   cur_trig_type  out  3   trigger type of the current or last event
//   cur_trig_num   out 24   trigger number of the current or last event
//   timeout_err    out  5   sticky per-channel timeout flags
//   seq_err        out  1   sticky trigger-number discontinuity flag
//   state          out  3   FSM state (IDLE=0 LOAD=1 SELECT=2 WAIT=3 DONE=4)
//
// Handshake:
//   The event word moves from the FIFO in the cycle where evt_valid and
//   evt_ready are both high. evt_valid may rise or fall at any time.
//   evt_ready does not depend on evt_valid. No word transfers in a cycle
//   where either signal is low.
//
// Optional feature (compile-time macro ACQ_SEQ_CHECK_EN):
//   Defined   - every pop after the first one since reset compares trig_num
//               with the previous trig_num + 1 (mod 2^24). A mismatch sets
//               seq_err, which stays set until reset.
//   Undefined - seq_err is tied low and no comparison logic is built.
// -----------------------------------------------------------------------------
module acq_readout_scheduler #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  chan_en,
   input  logic        evt_valid,
   input  logic [31:0] evt_data,
   output logic        evt_ready,
   output logic [4:0]  chan_rd_req,
   input  logic [4:0]  chan_rd_ack,
   output logic        readout_done,
   output logic [2:0]  cur_trig_type,
   output logic [23:0] cur_trig_num,
   output logic [4:0]  timeout_err,
   output logic        seq_err,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SELECT = 3'd2,
      S_WAIT   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [23:0] CNT_LAST = TIMEOUT_CYCLES - 24'd1;

   state_t      state_q, state_d;
   logic [4:0]  mask_q, mask_d;      // enable mask latched at pop
   logic [4:0]  pend_q, pend_d;      // channels still to be read out
   logic [23:0] cnt_q, cnt_d;        // WAIT cycle counter for the active channel
   logic [4:0]  req_q, req_d;        // one-hot request, also identifies the active channel
   logic [4:0]  terr_q, terr_d;
   logic [2:0]  type_q, type_d;
   logic [23:0] num_q, num_d;
   logic        done_q, done_d;
   logic        pop;
   logic [4:0]  lowest_pend;
   logic        sel_acked;
   logic        sel_timeout;

   // Bits 31:27 of the event word carry no information.
   logic unused_evt_bits;
   assign unused_evt_bits = ^evt_data[31:27];

   // Keeps only the lowest set bit of the pending set. This selects the
   // lowest-index pending channel as a one-hot value without a loop.
   assign lowest_pend = pend_q & (~pend_q + 5'd1);

   // Only the selected channel's ack counts. Acks on other channels are
   // masked out here, so they have no effect.
   assign sel_acked   = |(chan_rd_ack & req_q);
   assign sel_timeout = (cnt_q == CNT_LAST);

   // ---------------------------------------------------------------------------
   // Next-state and next-register logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      terr_d  = terr_q;
      type_d  = type_q;
      num_d   = num_q;
      done_d  = 1'b0;
      pop     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (evt_valid) begin
               pop     = 1'b1;
               type_d  = evt_data[26:24];
               num_d   = evt_data[23:0];
               mask_d  = chan_en;
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            pend_d  = mask_q;
            state_d = S_SELECT;
         end

         S_SELECT: begin
            if (pend_q == 5'd0) begin
               // done_q is registered, so it is high during the DONE cycle.
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               req_d   = lowest_pend;
               cnt_d   = 24'd0;
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            // The ack is tested before the timeout. If both happen in the
            // same cycle, the channel completes normally.
            if (sel_acked) begin
               pend_d  = pend_q & ~req_q;
               req_d   = 5'd0;
               state_d = S_SELECT;
            end else if (sel_timeout) begin
               terr_d  = terr_q | req_q;
               pend_d  = pend_q & ~req_q;
               req_d   = 5'd0;
               state_d = S_SELECT;
            end else begin
               cnt_d = cnt_q + 24'd1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         mask_q  <= 5'd0;
         pend_q  <= 5'd0;
         cnt_q   <= 24'd0;
         req_q   <= 5'd0;
         terr_q  <= 5'd0;
         type_q  <= 3'd0;
         num_q   <= 24'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         terr_q  <= terr_d;
         type_q  <= type_d;
         num_q   <= num_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Trigger-number continuity check
   // ---------------------------------------------------------------------------
`ifdef ACQ_SEQ_CHECK_EN
   logic        seen_q;   // a previous trig_num has been captured
   logic [23:0] prev_q;
   logic        seq_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q <= 1'b0;
         prev_q <= 24'd0;
         seq_q  <= 1'b0;
      end else if (pop) begin
         seen_q <= 1'b1;
         prev_q <= evt_data[23:0];
         // The 24-bit add wraps, so a step from 24'hFFFFFF to 0 counts as continuous.
         if (seen_q && (evt_data[23:0] != (prev_q + 24'd1))) begin
            seq_q <= 1'b1;
         end
      end
   end

   assign seq_err = seq_q;
`else
   logic unused_pop;
   assign unused_pop = pop;
   assign seq_err    = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign state         = state_q;
   assign evt_ready     = (state_q == S_IDLE);
   assign chan_rd_req   = req_q;
   assign readout_done  = done_q;
   assign cur_trig_type = type_q;
   assign cur_trig_num  = num_q;
   assign timeout_err   = terr_q;

endmodule

// File: tb/tb_acq_readout_scheduler.sv
// -----------------------------------------------------------------------------
// tb_acq_readout_scheduler
//
// Self-checking bench for acq_readout_scheduler, run with TIMEOUT_CYCLES = 16.
// For each event, a reference model builds the expected cycle-by-cycle timeline
// from the event's mask and the chosen ack delays. The timeline gives the
// expected state, the one-hot request, the acks to drive and the done cycle.
// The bench drives the DUT from that timeline and compares the DUT with it on
// every cycle.
// -----------------------------------------------------------------------------
module tb_acq_readout_scheduler;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  chan_en;
   logic        evt_valid;
   logic [31:0] evt_data;
   logic        evt_ready;
   logic [4:0]  chan_rd_req;
   logic [4:0]  chan_rd_ack;
   logic        readout_done;
   logic [2:0]  cur_trig_type;
   logic [23:0] cur_trig_num;
   logic [4:0]  timeout_err;
   logic        seq_err;
   logic [2:0]  state;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state that carries over from one event to the next.
   logic [4:0]  exp_terr = 5'd0;
   logic        exp_seq  = 1'b0;
   logic [23:0] last_num = 24'd0;
`ifdef ACQ_SEQ_CHECK_EN
   logic        exp_seen = 1'b0;
   logic [23:0] exp_prev = 24'd0;
`endif

   acq_readout_scheduler #(.TIMEOUT_CYCLES(24'(T))) dut (
      .clk           (clk),
      .reset         (reset),
      .chan_en       (chan_en),
      .evt_valid     (evt_valid),
      .evt_data      (evt_data),
      .evt_ready     (evt_ready),
      .chan_rd_req   (chan_rd_req),
      .chan_rd_ack   (chan_rd_ack),
      .readout_done  (readout_done),
      .cur_trig_type (cur_trig_type),
      .cur_trig_num  (cur_trig_num),
      .timeout_err   (timeout_err),
      .seq_err       (seq_err),
      .state         (state)
   );

   // ---------------------------------------------------------------------------
   // Clock
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 32'(state), 32'd0);
      check({tag, "_ready"}, 32'(evt_ready), 32'd1);
      check({tag, "_req"},   32'(chan_rd_req), 32'd0);
      check({tag, "_done"},  32'(readout_done), 32'd0);
      check({tag, "_type"},  32'(cur_trig_type), 32'd0);
      check({tag, "_num"},   32'(cur_trig_num), 32'd0);
      check({tag, "_terr"},  32'(timeout_err), 32'd0);
      check({tag, "_seq"},   32'(seq_err), 32'd0);
   endtask

   // Updates the sequence-error model when an event with trig_num tnum is popped.
   task automatic model_pop(input logic [23:0] tnum);
`ifdef ACQ_SEQ_CHECK_EN
      if (exp_seen && (tnum != exp_prev + 24'd1)) exp_seq = 1'b1;
      exp_seen = 1'b1;
      exp_prev = tnum;
`endif
      last_num = tnum;
   endtask

   task automatic model_reset();
      exp_terr = 5'd0;
      exp_seq  = 1'b0;
`ifdef ACQ_SEQ_CHECK_EN
      exp_seen = 1'b0;
      exp_prev = 24'd0;
`endif
   endtask

   // ---------------------------------------------------------------------------
   // Driver plus reference model for one event. This task is entered and left
   // 1 ns after a rising edge, with the DUT in IDLE.
   // dly[8c +: 8] is channel c's ack delay, counted in WAIT cycles. A delay of
   // T or more means the channel never acks.
   // ---------------------------------------------------------------------------
   task automatic run_event(input logic [4:0] mask, input logic [2:0] ttype,
                            input logic [23:0] tnum, input logic [39:0] dly,
                            input logic [4:0] force_noise, input bit rand_noise);
      logic [2:0] es [0:127];
      logic [4:0] er [0:127];
      logic [4:0] ea [0:127];
      int sel_c, len, d, done_c;
      logic [4:0] noise;

      for (int i = 0; i < 128; i++) begin
         es[i] = 3'd0; er[i] = 5'd0; ea[i] = 5'd0;
      end
      // Cycle 0 is the pop cycle. LOAD is cycle 1 and the first SELECT is
      // cycle 2. Each enabled channel then uses some WAIT cycles followed by
      // one SELECT cycle.
      es[1] = 3'd1;
      es[2] = 3'd2;
      sel_c = 2;
      for (int c = 0; c < 5; c++) begin
         if (mask[c]) begin
            d   = int'(dly[c*8 +: 8]);
            len = (d < T) ? d + 1 : T;
            for (int k = 0; k < len; k++) begin
               es[sel_c + 1 + k] = 3'd3;
               er[sel_c + 1 + k] = 5'd1 << c;
            end
            if (d < T) ea[sel_c + 1 + d] = 5'd1 << c;
            else       exp_terr[c] = 1'b1;
            sel_c = sel_c + 1 + len;
            es[sel_c] = 3'd2;
         end
      end
      done_c = sel_c + 1;
      es[done_c] = 3'd4;
      model_pop(tnum);

      check("pop_ready", 32'(evt_ready), 32'd1);
      evt_valid   = 1'b1;
      evt_data    = {5'd0, ttype, tnum};
      chan_en     = mask;
      chan_rd_ack = 5'd0;

      for (int t = 1; t <= done_c + 1; t++) begin
         @(posedge clk); #1;
         if (t == 1) begin
            // Stale valid, new data and a flipped mask while the event runs.
            // None of these may affect the event in progress.
            evt_valid = 1'($urandom_range(0, 1));
            evt_data  = $urandom;
            chan_en   = ~mask;
            check("trig_type", 32'(cur_trig_type), 32'(ttype));
            check("trig_num",  32'(cur_trig_num), 32'(tnum));
            check("seq_err",   32'(seq_err), 32'(exp_seq));
         end
         check("state", 32'(state), 32'(es[t]));
         check("req",   32'(chan_rd_req), 32'(er[t]));
         check("done",  32'(readout_done), 32'(t == done_c));
         check("ready", 32'(evt_ready), 32'(t == done_c + 1));
         if (t == done_c) check("timeout_err", 32'(timeout_err), 32'(exp_terr));
         if (t == done_c + 1) evt_valid = 1'b0;
         // Noise may hit any channel except the one currently selected.
         noise = force_noise | (rand_noise ? 5'($urandom_range(0, 31)) : 5'd0);
         noise = noise & ~er[t];
         chan_rd_ack = ea[t] | noise;
      end
      chan_rd_ack = 5'd0;
   endtask

   // Idle cycles: the DUT must stay in IDLE and ignore acks.
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         chan_rd_ack = 5'($urandom_range(0, 31));
         @(posedge clk); #1;
         check("idle_state", 32'(state), 32'd0);
         check("idle_req",   32'(chan_rd_req), 32'd0);
         check("idle_done",  32'(readout_done), 32'd0);
      end
      chan_rd_ack = 5'd0;
   endtask

   function automatic logic [39:0] rand_delays();
      logic [39:0] v;
      int r;
      v = 40'd0;
      for (int c = 0; c < 5; c++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      v[c*8 +: 8] = 8'($urandom_range(0, 6));
         else if (r < 8) v[c*8 +: 8] = 8'(T - 1);
         else            v[c*8 +: 8] = 8'(T + 2);
      end
      return v;
   endfunction

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      logic [23:0] tn;
      reset       = 1'b1;
      chan_en     = 5'd0;
      evt_valid   = 1'b0;
      evt_data    = 32'd0;
      chan_rd_ack = 5'd0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;

      // Mask 10101 with acks after 5 cycles: channels 0, 2 and 4 in order.
      run_event(5'b10101, 3'd3, 24'h000010, {8'd5, 8'd5, 8'd5, 8'd5, 8'd5}, 5'd0, 1'b0);
      // Channel 1 never acks and times out. Channel 2 acks after 3 cycles.
      run_event(5'b00110, 3'd1, 24'h000011, {8'd0, 8'd0, 8'd3, 8'(T + 5), 8'd0}, 5'd0, 1'b0);
      check("terr_ch1", 32'(timeout_err), 32'h2);
      // Ack on the exact timeout cycle, with a spurious ack on channel 4.
      run_event(5'b00001, 3'd2, 24'h000012, {8'd0, 8'd0, 8'd0, 8'd0, 8'(T - 1)}, 5'b10000, 1'b0);
      check("terr_after_tie", 32'(timeout_err), 32'h2);
      // Mask 0: DONE three cycles after the pop and no requests.
      run_event(5'b00000, 3'd7, 24'h000013, 40'd0, 5'd0, 1'b1);
      // Minimum event period: one channel that acks on its first WAIT cycle.
      run_event(5'b01000, 3'd0, 24'h000014, 40'd0, 5'd0, 1'b0);

      // Reset asserted mid-WAIT clears everything at once, without readout_done.
      check("rst_ready", 32'(evt_ready), 32'd1);
      evt_valid = 1'b1;
      evt_data  = {5'd0, 3'd5, 24'h000015};
      chan_en   = 5'b00100;
      @(posedge clk); #1;
      evt_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      check("rst_pre_state", 32'(state), 32'd3);
      check("rst_pre_req",   32'(chan_rd_req), 32'h4);
      #1 reset = 1'b1;
      #1 check_reset_values("async_rst");
      @(posedge clk); #1;
      check_reset_values("held_rst");
      reset = 1'b0;
      model_reset();

      // Trigger-number continuity across the 24-bit wrap, then a gap.
      run_event(5'b00001, 3'd1, 24'hFFFFFE, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, 5'd0, 1'b0);
      run_event(5'b00001, 3'd1, 24'hFFFFFF, {8'd0, 8'd0, 8'd0, 8'd0, 8'd2}, 5'd0, 1'b0);
      run_event(5'b00001, 3'd1, 24'h000000, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 5'd0, 1'b0);
      check("seq_after_wrap", 32'(seq_err), 32'd0);
      run_event(5'b00001, 3'd1, 24'h000002, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 5'd0, 1'b0);
`ifdef ACQ_SEQ_CHECK_EN
      check("seq_gap", 32'(seq_err), 32'd1);
`else
      check("seq_gap", 32'(seq_err), 32'd0);
`endif

      // Randomized events with random idle gaps and ack noise.
      for (int e = 0; e < 40; e++) begin
         idle_cycles($urandom_range(0, 3));
         tn = ($urandom_range(0, 3) == 0) ? 24'($urandom) : last_num + 24'd1;
         run_event(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), tn,
                   rand_delays(), 5'd0, 1'($urandom_range(0, 1)));
      end
      check("final_terr", 32'(timeout_err), 32'(exp_terr));
      check("final_seq",  32'(seq_err), 32'(exp_seq));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
